lsu_stbuf: RTL

- Store buffer directly upstream of the DCCM memory stage.
- Captures committed stores, already ECC-encoded, as lo/hi address and data pairs.
- Drains them in order onto the DCCM write port whenever the load pipe does not own the array.
- Flags a read-after-write hazard when a load targets a word still pending in the buffer.

---
 rtl/lsu_stbuf.sv | 128 ++++++++++++
 1 files changed

// File: rtl/lsu_stbuf.sv
// Store buffer ahead of the DCCM stage: queues committed ECC-encoded stores, drains them in order, flags load hazards.
// Optional LSU_STBUF_BYPASS_EN: a store into an empty, idle buffer is written to the DCCM in the same cycle.
module lsu_stbuf #(
   parameter int DCCM_BITS        = 16,
   parameter int DCCM_FDATA_WIDTH = 39,
   parameter int DCCM_WIDTH_BITS  = 2,
   parameter int STBUF_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stbuf_wr_vld,
   input  logic [DCCM_BITS-1:0]        stbuf_wr_addr_lo,
   input  logic [DCCM_BITS-1:0]        stbuf_wr_addr_hi,
   input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_wr_data_lo,
   input  logic [DCCM_FDATA_WIDTH-1:0] stbuf_wr_data_hi,
   input  logic                        ld_rden,
   input  logic [DCCM_BITS-1:0]        ld_addr_lo,
   input  logic [DCCM_BITS-1:0]        ld_addr_hi,
   output logic                        stbuf_full,
   output logic                        stbuf_empty,
   output logic                        stbuf_overflow,
   output logic                        ld_hazard,
   output logic                        dccm_wren,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr_lo,
   output logic [DCCM_BITS-1:0]        dccm_wr_addr_hi,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_lo,
   output logic [DCCM_FDATA_WIDTH-1:0] dccm_wr_data_hi
);

   localparam int PTR_W = $clog2(STBUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [STBUF_DEPTH-1:0]      valid_q;
   logic [DCCM_BITS-1:0]        addr_lo_q [STBUF_DEPTH];
   logic [DCCM_BITS-1:0]        addr_hi_q [STBUF_DEPTH];
   logic [DCCM_FDATA_WIDTH-1:0] data_lo_q [STBUF_DEPTH];
   logic [DCCM_FDATA_WIDTH-1:0] data_hi_q [STBUF_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             push;
   logic             drain;
   logic             bypass;
   logic             hit;
   logic             ld_addr_unused;

`ifdef LSU_STBUF_BYPASS_EN
   assign bypass = stbuf_empty & ~ld_rden & stbuf_wr_vld;
`else
   assign bypass = 1'b0;
`endif

   // A full buffer rejects the push even when a drain frees a slot this cycle.
   assign push  = stbuf_wr_vld & ~stbuf_full & ~bypass;
   assign drain = ~stbuf_empty & ~ld_rden;

   always_comb begin
      // NOTE: default first so every path assigns count_d and no latch is inferred.
      count_d = count_q;
      case ({push, drain})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         valid_q        <= '0;
         stbuf_full     <= 1'b0;
         stbuf_empty    <= 1'b1;
         stbuf_overflow <= 1'b0;
      end else begin
         count_q        <= count_d;
         stbuf_full     <= (count_d == CNT_W'(STBUF_DEPTH));
         stbuf_empty    <= (count_d == '0);
         stbuf_overflow <= stbuf_wr_vld & stbuf_full;
         // Push and drain never hit the same slot: that needs count 0 or full.
         if (push) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         if (drain) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // NOTE: payload array has no reset; valid_q alone decides whether an entry is live.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_lo_q[wr_ptr_q] <= stbuf_wr_addr_lo;
         addr_hi_q[wr_ptr_q] <= stbuf_wr_addr_hi;
         data_lo_q[wr_ptr_q] <= stbuf_wr_data_lo;
         data_hi_q[wr_ptr_q] <= stbuf_wr_data_hi;
      end
   end

   // Word-granular match of either load bank against either bank of any live entry, head included.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < STBUF_DEPTH; i++) begin
         if (valid_q[i] &&
             ((ld_addr_lo[DCCM_BITS-1:DCCM_WIDTH_BITS] == addr_lo_q[i][DCCM_BITS-1:DCCM_WIDTH_BITS]) ||
              (ld_addr_lo[DCCM_BITS-1:DCCM_WIDTH_BITS] == addr_hi_q[i][DCCM_BITS-1:DCCM_WIDTH_BITS]) ||
              (ld_addr_hi[DCCM_BITS-1:DCCM_WIDTH_BITS] == addr_lo_q[i][DCCM_BITS-1:DCCM_WIDTH_BITS]) ||
              (ld_addr_hi[DCCM_BITS-1:DCCM_WIDTH_BITS] == addr_hi_q[i][DCCM_BITS-1:DCCM_WIDTH_BITS])))
            hit = 1'b1;
      end
   end

   assign ld_hazard      = ld_rden & hit;
   assign ld_addr_unused = ^{ld_addr_lo[DCCM_WIDTH_BITS-1:0], ld_addr_hi[DCCM_WIDTH_BITS-1:0]};

   assign dccm_wren       = drain | bypass;
   assign dccm_wr_addr_lo = bypass ? stbuf_wr_addr_lo : addr_lo_q[rd_ptr_q];
   assign dccm_wr_addr_hi = bypass ? stbuf_wr_addr_hi : addr_hi_q[rd_ptr_q];
   assign dccm_wr_data_lo = bypass ? stbuf_wr_data_lo : data_lo_q[rd_ptr_q];
   assign dccm_wr_data_hi = bypass ? stbuf_wr_data_hi : data_hi_q[rd_ptr_q];

endmodule
